// File: rtl/debug_module_mh.sv
// Multi-hart RISC-V debug module: DMI register decode, per-hart halt/resume
// handshakes and an abstract access-register command engine with ack timeout.
module debug_module_mh #(
  parameter int NUM_HARTS      = 1,
  parameter int DATA_COUNT     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int HART_W        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iDmiValid,
  input  logic                 iDmiWrite,
  input  logic [6:0]           iDmiAddr,
  input  logic [31:0]          iDmiWdata,
  output logic [31:0]          oDmiRdata,
  output logic [NUM_HARTS-1:0] oHaltReq,
  output logic [NUM_HARTS-1:0] oResumeReq,
  input  logic [NUM_HARTS-1:0] iResumeAck,
  input  logic [NUM_HARTS-1:0] iHalted,
  output logic                 oNdmReset,
  output logic                 oRegReq,
  output logic [HART_W-1:0]    oRegHart,
  output logic                 oRegWrite,
  output logic [15:0]          oRegNo,
  output logic [31:0]          oRegWdata,
  input  logic                 iRegAck,
  input  logic                 iRegErr,
  input  logic [31:0]          iRegRdata
);

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                 state_q, state_d;
  logic                   dmactive_q, dmactive_d;
  logic                   ndmreset_q, ndmreset_d;
  logic [9:0]             hartsel_q, hartsel_d;
  logic [NUM_HARTS-1:0]   haltreq_q, haltreq_d;
  logic [NUM_HARTS-1:0]   resumereq_q, resumereq_d;
  logic [NUM_HARTS-1:0]   resumeack_q, resumeack_d;
  logic [2:0]             cmderr_q, cmderr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            data_q [DATA_COUNT];
  logic [31:0]            data_d [DATA_COUNT];
  logic [HART_W-1:0]      reg_hart_q, reg_hart_d;
  logic                   reg_write_q, reg_write_d;
  logic [15:0]            reg_no_q, reg_no_d;
  logic [31:0]            reg_wdata_q, reg_wdata_d;

  logic        busy;
  logic        wr;
  logic        hart_exists;
  logic        sel_halted;
  logic        sel_haltreq;
  logic        sel_resumeack;
  logic        data_hit;
  logic [31:0] data_rd;
  logic        unused_bits;

  assign unused_bits = ^{iDmiWdata[23], iDmiWdata[19]};

  assign busy        = (state_q == REQ);
  assign wr          = iDmiValid & iDmiWrite;
  assign hart_exists = ({1'b0, hartsel_q} < 11'(NUM_HARTS));

  // Per-hart status of the currently selected hart, and data* address decode
  always_comb begin
    sel_halted    = 1'b0;
    sel_haltreq   = 1'b0;
    sel_resumeack = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hartsel_q == 10'(h)) begin
        sel_halted    = iHalted[h];
        sel_haltreq   = haltreq_q[h];
        sel_resumeack = resumeack_q[h];
      end
    end
    data_hit = 1'b0;
    data_rd  = '0;
    for (int i = 0; i < DATA_COUNT; i++) begin
      if (iDmiAddr == ADDR_DATA0 + 7'(i)) begin
        data_hit = 1'b1;
        data_rd  = data_q[i];
      end
    end
  end

  always_comb begin
    oDmiRdata = '0;
    if (!iDmiWrite) begin
      case (iDmiAddr)
        ADDR_DMCONTROL: begin
          oDmiRdata[31]    = sel_haltreq;
          oDmiRdata[25:16] = hartsel_q;
          oDmiRdata[1]     = ndmreset_q;
          oDmiRdata[0]     = dmactive_q;
        end
        ADDR_DMSTATUS: begin
          oDmiRdata[3:0] = 4'd3;
          oDmiRdata[7]   = 1'b1;
          if (hart_exists) begin
            oDmiRdata[9:8]   = {2{sel_halted}};
            oDmiRdata[11:10] = {2{~sel_halted}};
            oDmiRdata[17:16] = {2{sel_resumeack}};
          end else begin
            oDmiRdata[15:14] = 2'b11;
          end
        end
        ADDR_ABSTRACTCS: begin
          oDmiRdata[12]   = busy;
          oDmiRdata[10:8] = cmderr_q;
          oDmiRdata[3:0]  = 4'(DATA_COUNT);
        end
        default: begin
          if (data_hit && !busy) oDmiRdata = data_rd;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    dmactive_d  = dmactive_q;
    ndmreset_d  = ndmreset_q;
    hartsel_d   = hartsel_q;
    haltreq_d   = haltreq_q;
    resumereq_d = resumereq_q;
    resumeack_d = resumeack_q;
    cmderr_d    = cmderr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    reg_hart_d  = reg_hart_q;
    reg_write_d = reg_write_q;
    reg_no_d    = reg_no_q;
    reg_wdata_d = reg_wdata_q;

    if (dmactive_q) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (iResumeAck[h]) begin
          resumereq_d[h] = 1'b0;
          resumeack_d[h] = 1'b1;
        end
      end

      if (state_q == REQ) begin
        if (iRegAck) begin
          if (iRegErr)           cmderr_d  = 3'd3;
          else if (!reg_write_q) data_d[0] = iRegRdata;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cmderr_d = 3'd3;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // DMI writes; a new resume request overrides an ack in the same cycle
    if (wr) begin
      if (iDmiAddr == ADDR_DMCONTROL) begin
        dmactive_d = iDmiWdata[0];
        if (dmactive_q) begin
          ndmreset_d = iDmiWdata[1];
          hartsel_d  = iDmiWdata[25:16];
          for (int h = 0; h < NUM_HARTS; h++) begin
            if (iDmiWdata[25:16] == 10'(h)) begin
              haltreq_d[h] = iDmiWdata[31];
              if (iDmiWdata[30] && !iDmiWdata[31]) begin
                resumereq_d[h] = 1'b1;
                resumeack_d[h] = 1'b0;
              end
            end
          end
        end
      end else if (dmactive_q) begin
        if (busy && (iDmiAddr == ADDR_COMMAND || iDmiAddr == ADDR_ABSTRACTCS || data_hit)) begin
          if (cmderr_d == 3'd0) cmderr_d = 3'd1;
        end else if (iDmiAddr == ADDR_ABSTRACTCS) begin
          cmderr_d = cmderr_q & ~iDmiWdata[10:8];
        end else if (iDmiAddr == ADDR_COMMAND) begin
          if (cmderr_q == 3'd0) begin
            if (iDmiWdata[31:24] != 8'd0 || iDmiWdata[22:20] != 3'd2 || iDmiWdata[18]) begin
              cmderr_d = 3'd2;
            end else if (!hart_exists || !sel_halted) begin
              cmderr_d = 3'd4;
            end else if (iDmiWdata[17]) begin
              state_d     = REQ;
              cnt_d       = '0;
              reg_hart_d  = hartsel_q[HART_W-1:0];
              reg_write_d = iDmiWdata[16];
              reg_no_d    = iDmiWdata[15:0];
              reg_wdata_d = data_q[0];
            end
          end
        end else begin
          for (int i = 0; i < DATA_COUNT; i++) begin
            if (iDmiAddr == ADDR_DATA0 + 7'(i)) data_d[i] = iDmiWdata;
          end
        end
      end
    end
  end

  // Clearing dmactive resets the whole module on the same edge
  always_ff @(posedge iClk) begin
    if (iRst || !dmactive_d) begin
      state_q     <= IDLE;
      dmactive_q  <= 1'b0;
      ndmreset_q  <= 1'b0;
      hartsel_q   <= '0;
      haltreq_q   <= '0;
      resumereq_q <= '0;
      resumeack_q <= '0;
      cmderr_q    <= '0;
      cnt_q       <= '0;
      reg_hart_q  <= '0;
      reg_write_q <= 1'b0;
      reg_no_q    <= '0;
      reg_wdata_q <= '0;
      for (int i = 0; i < DATA_COUNT; i++) data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      dmactive_q  <= dmactive_d;
      ndmreset_q  <= ndmreset_d;
      hartsel_q   <= hartsel_d;
      haltreq_q   <= haltreq_d;
      resumereq_q <= resumereq_d;
      resumeack_q <= resumeack_d;
      cmderr_q    <= cmderr_d;
      cnt_q       <= cnt_d;
      reg_hart_q  <= reg_hart_d;
      reg_write_q <= reg_write_d;
      reg_no_q    <= reg_no_d;
      reg_wdata_q <= reg_wdata_d;
      for (int i = 0; i < DATA_COUNT; i++) data_q[i] <= data_d[i];
    end
  end

  assign oHaltReq   = haltreq_q;
  assign oResumeReq = resumereq_q;
  assign oNdmReset  = ndmreset_q;
  assign oRegReq    = busy;
  assign oRegHart   = reg_hart_q;
  assign oRegWrite  = reg_write_q;
  assign oRegNo     = reg_no_q;
  assign oRegWdata  = reg_wdata_q;

endmodule

// File: tb/tb_debug_module_mh.sv
// Directed bench for debug_module_mh with two harts and a short ack timeout.
module tb_debug_module_mh;

  localparam int NH  = 2;
  localparam int DC  = 2;
  localparam int TMO = 10;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iDmiValid, iDmiWrite;
  logic [6:0]    iDmiAddr;
  logic [31:0]   iDmiWdata;
  logic [31:0]   oDmiRdata;
  logic [NH-1:0] oHaltReq, oResumeReq, iResumeAck, iHalted;
  logic          oNdmReset, oRegReq, oRegWrite;
  logic [0:0]    oRegHart;
  logic [15:0]   oRegNo;
  logic [31:0]   oRegWdata;
  logic          iRegAck, iRegErr;
  logic [31:0]   iRegRdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd;
  int cyc;

  debug_module_mh #(.NUM_HARTS(NH), .DATA_COUNT(DC), .TIMEOUT_CYCLES(TMO)) dut (
    .iClk(iClk), .iRst(iRst),
    .iDmiValid(iDmiValid), .iDmiWrite(iDmiWrite), .iDmiAddr(iDmiAddr),
    .iDmiWdata(iDmiWdata), .oDmiRdata(oDmiRdata),
    .oHaltReq(oHaltReq), .oResumeReq(oResumeReq), .iResumeAck(iResumeAck),
    .iHalted(iHalted), .oNdmReset(oNdmReset),
    .oRegReq(oRegReq), .oRegHart(oRegHart), .oRegWrite(oRegWrite),
    .oRegNo(oRegNo), .oRegWdata(oRegWdata),
    .iRegAck(iRegAck), .iRegErr(iRegErr), .iRegRdata(iRegRdata)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called and returns one time unit after a rising edge
  task automatic dmi_write(input logic [6:0] addr, input logic [31:0] data);
    iDmiValid = 1'b1; iDmiWrite = 1'b1; iDmiAddr = addr; iDmiWdata = data;
    @(posedge iClk); #1;
    iDmiValid = 1'b0; iDmiWrite = 1'b0;
  endtask

  task automatic dmi_read(input logic [6:0] addr, output logic [31:0] data);
    iDmiValid = 1'b1; iDmiWrite = 1'b0; iDmiAddr = addr;
    #1;
    data = oDmiRdata;
    iDmiValid = 1'b0;
  endtask

  task automatic reg_ack(input logic err, input logic [31:0] rdata);
    iRegAck = 1'b1; iRegErr = err; iRegRdata = rdata;
    @(posedge iClk); #1;
    iRegAck = 1'b0; iRegErr = 1'b0;
  endtask

  initial begin
    iRst = 1'b1; iDmiValid = 1'b0; iDmiWrite = 1'b0; iDmiAddr = '0; iDmiWdata = '0;
    iResumeAck = '0; iHalted = '0; iRegAck = 1'b0; iRegErr = 1'b0; iRegRdata = '0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;

    check("rst_haltreq", 32'(oHaltReq), 32'h0);
    check("rst_regreq", 32'(oRegReq), 32'h0);
    check("rst_resumereq", 32'(oResumeReq), 32'h0);
    check("rst_ndmreset", 32'(oNdmReset), 32'h0);
    dmi_read(7'h11, rd); check("rst_dmstatus", rd, 32'h0000_0C83);
    dmi_read(7'h16, rd); check("rst_abstractcs", rd, 32'h0000_0002);

    // Activate, halt hart 0
    dmi_write(7'h10, 32'h0000_0001);
    dmi_write(7'h10, 32'h8000_0001);
    check("halt_req0", 32'(oHaltReq), 32'h1);
    dmi_read(7'h10, rd); check("dmcontrol_rd", rd, 32'h8000_0001);
    iHalted = 2'b01; #1;
    dmi_read(7'h11, rd); check("dmstatus_halted", rd, 32'h0000_0383);

    // Read x5 on hart 1
    dmi_write(7'h10, 32'h0001_0001);
    iHalted = 2'b11;
    dmi_write(7'h17, 32'h0022_1005);
    check("rd_regreq", 32'(oRegReq), 32'h1);
    check("rd_regno", 32'(oRegNo), 32'h1005);
    check("rd_reghart", 32'(oRegHart), 32'h1);
    check("rd_regwrite", 32'(oRegWrite), 32'h0);
    dmi_read(7'h16, rd); check("rd_busy", rd, 32'h0000_1002);
    @(posedge iClk); #1;
    reg_ack(1'b0, 32'hDEAD_BEEF);
    check("rd_done_req", 32'(oRegReq), 32'h0);
    dmi_read(7'h16, rd); check("rd_done_acs", rd, 32'h0000_0002);
    dmi_read(7'h04, rd); check("rd_data0", rd, 32'hDEAD_BEEF);

    // Command to a running hart, then illegal cmdtype
    dmi_write(7'h04, 32'h0000_1234);
    iHalted = 2'b01;
    dmi_write(7'h17, 32'h0023_0300);
    check("run_noreq", 32'(oRegReq), 32'h0);
    dmi_read(7'h16, rd); check("run_cmderr4", rd, 32'h0000_0402);
    dmi_write(7'h16, 32'h0000_0400);
    dmi_read(7'h16, rd); check("w1c_cmderr", rd, 32'h0000_0002);
    iHalted = 2'b11;
    dmi_write(7'h17, 32'h0122_1005);
    dmi_read(7'h16, rd); check("bad_cmdtype", rd, 32'h0000_0202);
    check("bad_noreq", 32'(oRegReq), 32'h0);
    dmi_write(7'h16, 32'h0000_0700);

    // Timeout: no ack
    dmi_write(7'h17, 32'h0022_1007);
    check("tmo_wdata", oRegWdata, 32'h0000_1234);
    cyc = 0;
    while (oRegReq && cyc < 100) begin
      @(posedge iClk); #1;
      cyc++;
    end
    check("tmo_cycles", 32'(cyc), 32'(TMO));
    check("tmo_regreq", 32'(oRegReq), 32'h0);
    dmi_read(7'h16, rd); check("tmo_cmderr3", rd, 32'h0000_0302);
    reg_ack(1'b0, 32'h5555_5555);
    dmi_read(7'h04, rd); check("late_ack_ignored", rd, 32'h0000_1234);
    dmi_write(7'h16, 32'h0000_0700);

    // Write while busy, then error ack
    dmi_write(7'h17, 32'h0022_1008);
    dmi_write(7'h17, 32'h0022_1008);
    dmi_read(7'h16, rd); check("busy_cmderr1", rd, 32'h0000_1102);
    dmi_read(7'h04, rd); check("busy_data_rd0", rd, 32'h0);
    reg_ack(1'b1, 32'hFFFF_FFFF);
    dmi_read(7'h16, rd); check("err_cmderr3", rd, 32'h0000_0302);
    dmi_read(7'h04, rd); check("err_data_kept", rd, 32'h0000_1234);
    dmi_write(7'h16, 32'h0000_0700);

    // Resume hart 0
    dmi_write(7'h10, 32'h4000_0001);
    check("resume_req", 32'(oResumeReq), 32'h1);
    check("resume_haltclr", 32'(oHaltReq), 32'h0);
    dmi_read(7'h11, rd); check("resume_noack", rd, 32'h0000_0383);
    iResumeAck = 2'b01;
    @(posedge iClk); #1;
    iResumeAck = 2'b00;
    check("resume_reqclr", 32'(oResumeReq), 32'h0);
    dmi_read(7'h11, rd); check("resume_ack", rd, 32'h0003_0383);

    // Nonexistent hart, ndmreset, then deactivate
    dmi_write(7'h10, 32'h8001_0001);
    check("halt_req1", 32'(oHaltReq), 32'h2);
    dmi_write(7'h10, 32'h0005_0003);
    check("ndmreset", 32'(oNdmReset), 32'h1);
    dmi_read(7'h11, rd); check("nonexistent", rd, 32'h0000_C083);
    dmi_read(7'h10, rd); check("dmcontrol_h5", rd, 32'h0005_0003);
    dmi_write(7'h10, 32'h0000_0000);
    check("off_haltreq", 32'(oHaltReq), 32'h0);
    check("off_ndmreset", 32'(oNdmReset), 32'h0);
    dmi_read(7'h10, rd); check("off_dmcontrol", rd, 32'h0);
    dmi_write(7'h04, 32'h0000_0099);
    dmi_write(7'h10, 32'h0000_0001);
    dmi_read(7'h04, rd); check("off_data_cleared", rd, 32'h0);

    // Abort an access by clearing dmactive
    dmi_write(7'h10, 32'h0001_0001);
    dmi_write(7'h17, 32'h0022_1005);
    check("abort_pre", 32'(oRegReq), 32'h1);
    dmi_write(7'h10, 32'h0000_0000);
    check("abort_regreq", 32'(oRegReq), 32'h0);
    dmi_read(7'h16, rd); check("abort_acs", rd, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
